// File: rtl/fetch_db_store_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_db_store_ctrl
//   Scheduler for the deblocked-LCU triple buffer in the fetch stage. Keeps a
//   fill count of finished LCU buffers (db_done_i in, store_done_o out), sweeps
//   the store read port over word 0..WORDS-1 of each full buffer, and delivers
//   the words on a valid/ready stream through a 2-entry output FIFO.
//
//   Optional feature macro: FETCH_DB_STORE_STAT_EN
//     defined   -> adds stall_cnt_o[15:0], a saturating count of stalled cycles
//                  (out_valid_o & ~out_ready_i), cleared on store_done_o
//     undefined -> port and counter absent
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   db_done_i      pulse, deblocking finished one LCU buffer
//   buf_full_o     all NBUF buffers full
//   store_ready_o  at least one buffer full
//   store_en_o     buffer store read enable
//   store_addr_o   buffer store read word address
//   store_data_i   buffer store read data, valid one cycle after store_en_o
//   store_done_o   pulse, current buffer fully delivered
//   out_valid_o    stream valid
//   out_ready_i    stream ready
//   out_data_o     stream data word
//   out_last_o     marks word WORDS-1 of an LCU
//   ovf_err_o      sticky, db_done_i arrived with all buffers full
//   stall_cnt_o    (FETCH_DB_STORE_STAT_EN only) stalled-cycle counter
// ---------------------------------------------------------------------------
module fetch_db_store_ctrl #(
  parameter int PIXEL_WIDTH = 8,
  parameter int WORDS       = 192,
  parameter int NBUF        = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      db_done_i,
  output logic                      buf_full_o,
  output logic                      store_ready_o,
  output logic                      store_en_o,
  output logic [7:0]                store_addr_o,
  input  logic [32*PIXEL_WIDTH-1:0] store_data_i,
  output logic                      store_done_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [32*PIXEL_WIDTH-1:0] out_data_o,
  output logic                      out_last_o,
`ifdef FETCH_DB_STORE_STAT_EN
  output logic [15:0]               stall_cnt_o,
`endif
  output logic                      ovf_err_o
);

  localparam int DW = 32 * PIXEL_WIDTH;
  localparam int CW = $clog2(NBUF + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e          state_q;
  logic [7:0]      addr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            bufFull_q, storeReady_q, ovf_q;

  logic [DW-1:0]   fifoData_q [2];
  logic            fifoLast_q [2];
  logic            wrPtr_q, rdPtr_q;
  logic [1:0]      fifoCnt_q, fifoCnt_d;
  logic            inflight_q, inflightLast_q;

  logic            pop, issue, isLast;

  assign pop    = (fifoCnt_q != 2'd0) && out_ready_i;
  assign isLast = (addr_q == 8'(WORDS - 1));

  // Occupancy after this cycle's pop and the landing in-flight word. A new
  // read is only issued when it still leaves room, so the FIFO can never be
  // overrun even if out_ready_i drops right after the read is issued.
  assign fifoCnt_d = fifoCnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue     = (state_q == READ) && (fifoCnt_d < 2'd2);

  assign store_en_o    = issue;
  assign store_addr_o  = addr_q;
  assign store_done_o  = (state_q == DONE);
  assign out_valid_o   = (fifoCnt_q != 2'd0);
  assign out_data_o    = fifoData_q[rdPtr_q];
  assign out_last_o    = fifoLast_q[rdPtr_q];
  assign buf_full_o    = bufFull_q;
  assign store_ready_o = storeReady_q;
  assign ovf_err_o     = ovf_q;

  // Fill count: simultaneous produce/consume cancels; produce alone saturates.
  always_comb begin
    count_d = count_q;
    unique case ({db_done_i, store_done_o})
      2'b10:   if (count_q != CW'(NBUF)) count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q      <= '0;
      bufFull_q    <= 1'b0;
      storeReady_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      bufFull_q    <= (count_d == CW'(NBUF));
      storeReady_q <= (count_d != '0);
      if (db_done_i && !store_done_o && (count_q == CW'(NBUF)))
        ovf_q <= 1'b1;
    end
  end

  // Sweep FSM. DRAIN exits as soon as the last word is being accepted, so
  // DONE follows the final beat directly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          addr_q <= 8'd0;
          if (count_q != '0) state_q <= READ;
        end
        READ: begin
          if (issue) begin
            if (isLast) state_q <= DRAIN;
            else        addr_q  <= addr_q + 8'd1;
          end
        end
        DRAIN: begin
          if (!inflight_q && (fifoCnt_d == 2'd0)) state_q <= DONE;
        end
        DONE: begin
          addr_q  <= 8'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output FIFO: the read issued last cycle lands this cycle with its tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      wrPtr_q        <= 1'b0;
      rdPtr_q        <= 1'b0;
      fifoCnt_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifoData_q[i] <= '0;
        fifoLast_q[i] <= 1'b0;
      end
    end else begin
      inflight_q     <= issue;
      inflightLast_q <= issue && isLast;
      fifoCnt_q      <= fifoCnt_d;
      if (inflight_q) begin
        fifoData_q[wrPtr_q] <= store_data_i;
        fifoLast_q[wrPtr_q] <= inflightLast_q;
        wrPtr_q             <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
    end
  end

`ifdef FETCH_DB_STORE_STAT_EN
  logic [15:0] stallCnt_q;
  assign stall_cnt_o = stallCnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stallCnt_q <= 16'd0;
    end else if (store_done_o) begin
      stallCnt_q <= 16'd0;
    end else if (out_valid_o && !out_ready_i && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_q <= stallCnt_q + 16'd1;
    end
  end
`endif

endmodule
